switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Conditions raw, asynchronous board inputs (ML605 DIP switches and pushbuttons)
//   before the counter/LED logic uses them. Per channel:
//   - synchronises the input to sys_clk and filters out contact bounce;
//   - outputs a clean level, one-cycle rise/fall pulses, and a press-event pulse
//     with hold-to-auto-repeat.
//   This is the input-side companion to the LED output path; it sits between the
//   board pins and the control logic.
// PARAMETERS
//   N_IN            8            number of independent input channels
//   SYNC_STAGES     2            synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES 2_000_000    consecutive stable cycles needed to accept a change (10 ms @ 200 MHz), >=1
//   REPEAT_EN       1            1 = auto-repeat press_evt while held; 0 = press_evt on rise only
//   REPEAT_DELAY    100_000_000  cycles from accepted press to first repeat pulse (500 ms), >=1
//   REPEAT_PERIOD   20_000_000   cycles between subsequent repeat pulses (100 ms), >=1
// PORTS
//   sys_clk    in   1     single system clock, all logic on posedge
//   reset      in   1     synchronous, active-high reset
//   raw_in     in   N_IN  asynchronous raw switch/button inputs, active-high
//   level      out  N_IN  debounced level
//   rise       out  N_IN  1-cycle pulse when level goes 0->1
//   fall       out  N_IN  1-cycle pulse when level goes 1->0
//   press_evt  out  N_IN  1-cycle pulse on rise, then on auto-repeat ticks
// BEHAVIOUR
//   - Reset: on any posedge with reset=1, clear everything: synchroniser flops,
//     counters, FSMs, level, rise, fall and press_evt all go to 0. Reset wins over
//     every other event in that cycle.
//   - Synchroniser: s[i] is raw_in[i] delayed by SYNC_STAGES flops.
//   - Debounce counter: dcnt[i], width $clog2(DEBOUNCE_CYCLES+1).
//     - If s[i]==level[i]: dcnt <= 0.
//     - If s[i]!=level[i] and dcnt==DEBOUNCE_CYCLES-1, on that edge:
//       level toggles, dcnt <= 0, and rise or fall is asserted for exactly that
//       one cycle. The pulse is registered and appears together with the new level.
//     - Otherwise dcnt increments.
//   - Latency: a clean raw step is reflected on level/rise exactly
//     SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first sampling edge.
//   - Glitch shorter than DEBOUNCE_CYCLES: dcnt clears; no level change, no pulse.
//   - rise and fall are never asserted together on one channel. Channels are
//     fully independent; simultaneous changes on several channels each produce
//     their own pulses in the same cycle.
//   - Repeat FSM per channel, counter rcnt with width sized for
//     max(REPEAT_DELAY, REPEAT_PERIOD):
//     - IDLE:  on rise: press_evt=1, rcnt<=0, go DELAY.
//     - DELAY: rcnt increments. At rcnt==REPEAT_DELAY-1: press_evt=1, rcnt<=0,
//       go RPT. With REPEAT_EN=0, stay in DELAY with rcnt saturated and no pulse.
//     - RPT:   rcnt increments. At rcnt==REPEAT_PERIOD-1: press_evt=1, rcnt<=0.
//     - Any state, on fall: go IDLE, rcnt<=0, press_evt=0.
//   - Wrap-around: no counter ever wraps. dcnt is bounded by the compare; rcnt is
//     cleared or saturated.
//   - Input high at reset release: level rises after SYNC_STAGES+DEBOUNCE_CYCLES
//     cycles and emits rise plus press_evt (intended power-on behaviour).
// TESTING (bench params: N_IN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1. Reset, then raw_in[0] 0->1 held. Required: level[0], rise[0] and press_evt[0]
//      go high together exactly 6 cycles later; rise[0] lasts 1 cycle.
//   2. raw_in[0] high for 3 cycles, then low (glitch). Required: level, rise and
//      press_evt stay 0 throughout.
//   3. Hold raw_in[0]=1 for 30 cycles past acceptance. Required: press_evt pulses at
//      offsets 0, 10, 13, 16, ..., 28; release gives fall after 6 cycles and no further pulses.
//   4. Same as test 3 with REPEAT_EN=0. Required: exactly one press_evt pulse
//      (offset 0) for the whole hold.
//   5. raw_in=2'b11 in one cycle. Required: both rise bits assert in the same cycle.
//      Then a bouncing release 1,0,1,0 on ch1 only, then stable 0. Required: a single
//      fall[1] pulse; ch0 unaffected.
//   6. Assert reset for 1 cycle during the RPT state with raw_in held. Required: all
//      outputs 0 the next cycle; rise and press_evt reappear 6 cycles after reset drops.

Source files
------------

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button conditioner: synchroniser, bounce filter, edge pulses
// and a press-event generator with optional hold-to-auto-repeat.
module switch_debouncer_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 100_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press_evt
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RPT} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_dcnt;
  logic                   r_level, r_rise, r_fall, r_press;
  logic [RW-1:0]          r_rcnt, w_rcnt_nxt;
  state_t                 r_state, w_state_nxt;
  logic                   w_s, w_diff, w_accept, w_rise, w_fall, w_press_nxt;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = (w_s != r_level);
  assign w_accept = w_diff && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_rise   = w_accept && !r_level;
  assign w_fall   = w_accept && r_level;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_dcnt  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_press <= 1'b0;
      r_rcnt  <= '0;
      r_state <= S_IDLE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
      // Counter only runs while the synced input disagrees with the accepted level
      if (!w_diff || w_accept) r_dcnt <= '0;
      else                     r_dcnt <= r_dcnt + 1'b1;
      if (w_accept) r_level <= !r_level;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_press <= w_press_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_press_nxt = 1'b0;
    if (w_fall) begin
      w_state_nxt = S_IDLE;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rise) begin
          w_press_nxt = 1'b1;
          w_rcnt_nxt  = '0;
          w_state_nxt = S_DELAY;
        end
        S_DELAY: begin
          // Without repeat the counter parks at its terminal value instead of wrapping
          if (REPEAT_EN == 0) begin
            if (r_rcnt != RW'(REPEAT_DELAY - 1)) w_rcnt_nxt = r_rcnt + 1'b1;
          end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = '0;
            w_state_nxt = S_RPT;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        S_RPT: begin
          if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign level     = r_level;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign press_evt = r_press;
endmodule

module switch_debouncer #(
  parameter int N_IN            = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 100_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic [N_IN-1:0] press_evt
);
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
    switch_debouncer_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .raw_in   (raw_in[gi]),
      .level    (level[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi]),
      .press_evt(press_evt[gi])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (auto-repeat on/off) share one stimulus;
// expectations are queued at drive time and checked when due.
module tb_switch_debouncer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] level, rise, fall, pe;
  logic [1:0] level0, rise0, fall0, pe0;

  always #5 clk = ~clk;

  switch_debouncer #(.N_IN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_dut (
    .sys_clk(clk), .reset(reset), .raw_in(raw_in),
    .level(level), .rise(rise), .fall(fall), .press_evt(pe));

  switch_debouncer #(.N_IN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_dut0 (
    .sys_clk(clk), .reset(reset), .raw_in(raw_in),
    .level(level0), .rise(rise0), .fall(fall0), .press_evt(pe0));

  typedef struct {
    int          due;
    logic [15:0] v;
    string       tag;
  } exp_t;

  typedef struct {
    int         n;
    logic [1:0] raw, lvl, ri, fa, pe, pe0;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] pack(logic [1:0] l, logic [1:0] r, logic [1:0] f,
                                       logic [1:0] p, logic [1:0] p0);
    return {l, r, f, p, p0, l, r, f};
  endfunction

  task automatic push_exp(int d, logic [1:0] l, logic [1:0] r, logic [1:0] f,
                          logic [1:0] p, logic [1:0] p0, string tag);
    exp_t e;
    e.due = cyc + d;
    e.v   = pack(l, r, f, p, p0);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare every entry due this cycle, well after the edge
  always @(posedge clk) begin
    logic [15:0] got;
    #2;
    got = {level, rise, fall, pe, pe0, level0, rise0, fall0};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due == cyc) begin
        n_tests++;
        if (got !== exp_q[i].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got lvl/ri/fa/pe/pe0=%b/%b/%b/%b/%b (norep %b/%b/%b) expected %b",
                   exp_q[i].tag, cyc, level, rise, fall, pe, pe0, level0, rise0, fall0, exp_q[i].v);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int o;
    logic l, r, f, p, p0;
    reset  = 1'b1;
    raw_in = 2'b11;

    // Reset wins even with inputs high
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      push_exp(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    end
    @(negedge clk);
    raw_in = 2'b00;
    reset  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_exp(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "post_reset");
      @(negedge clk);
    end

    // Press/release ch0, then a 3-cycle glitch
    tbl.push_back('{5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01});
    tbl.push_back('{1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    // Both channels together, bouncing ch1 release, then ch0 release mid-repeat
    tbl.push_back('{5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11});
    tbl.push_back('{3, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{4, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{2, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    foreach (tbl[t]) begin
      for (int k = 0; k < tbl[t].n; k++) begin
        push_exp(1, tbl[t].lvl, tbl[t].ri, tbl[t].fa, tbl[t].pe, tbl[t].pe0,
                 $sformatf("vec%0d.%0d", t, k));
        raw_in = tbl[t].raw;
        @(negedge clk);
      end
    end

    // Long hold on ch0: repeat ticks run until the debounced fall
    for (int d = 1; d <= 44; d++) begin
      o  = d - 6;
      l  = (o >= 0) && (o < 36);
      r  = (o == 0);
      f  = (o == 36);
      p  = (o == 0) || ((o >= 10) && (o < 36) && ((o - 10) % 3 == 0));
      p0 = (o == 0);
      push_exp(d, {1'b0, l}, {1'b0, r}, {1'b0, f}, {1'b0, p}, {1'b0, p0},
               $sformatf("hold_o%0d", o));
    end
    raw_in = 2'b01;
    repeat (36) @(negedge clk);
    raw_in = 2'b00;
    repeat (10) @(negedge clk);

    // Reset pulse while in auto-repeat with the button still held
    for (int d = 1; d <= 28; d++) begin
      o = d - 6;
      if (d <= 20) begin
        l  = (o >= 0);
        r  = (o == 0);
        p  = (o == 0) || ((o >= 10) && ((o - 10) % 3 == 0));
        p0 = (o == 0);
      end else begin
        l  = (d >= 27);
        r  = (d == 27);
        p  = (d == 27);
        p0 = (d == 27);
      end
      push_exp(d, {1'b0, l}, {1'b0, r}, 2'b00, {1'b0, p}, {1'b0, p0},
               $sformatf("rst_rpt_d%0d", d));
    end
    raw_in = 2'b01;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    raw_in = 2'b00;
    repeat (10) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
